one_wire_slot_timer: RTL and testbench

Parametrised 1-Wire slot timing engine: from a single start strobe it generates the bus-low, release, sample and recovery phases for reset/presence, write-0, write-1 and read slots, at standard or overdrive speed. It sits between the byte-level 1-Wire controller and the open-drain DQ pad. It replaces the fixed standard-speed timing constants with a clock-frequency-generic counter-based sequencer.

---
 rtl/one_wire_pkg.sv | 75 +++++++
 rtl/one_wire_tick_gen.sv | 29 ++
 rtl/one_wire_slot_timer.sv | 158 +++++++++++++++
 tb/tb_one_wire_slot_timer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/one_wire_pkg.sv
// Shared 1-Wire slot timing definitions: encodings and phase durations in qus.
package one_wire_pkg;

   localparam int unsigned QUS_PER_US = 4;
   localparam int unsigned TICK_HZ    = QUS_PER_US * 1_000_000;
   localparam int unsigned DUR_W      = 11;

   // Slot-type encodings
   localparam logic [1:0] SLOT_RESET  = 2'b00;
   localparam logic [1:0] SLOT_WRITE0 = 2'b01;
   localparam logic [1:0] SLOT_WRITE1 = 2'b10;
   localparam logic [1:0] SLOT_READ   = 2'b11;

   // Sequencer state encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOW  = 2'd1;
   localparam logic [1:0] ST_REL  = 2'd2;
   localparam logic [1:0] ST_REC  = 2'd3;

   // Standard-speed durations (qus)
   localparam logic [DUR_W-1:0] STD_RESET_LOW  = 11'd1920;
   localparam logic [DUR_W-1:0] STD_RESET_REL  = 11'd280;
   localparam logic [DUR_W-1:0] STD_RESET_REC  = 11'd1640;
   localparam logic [DUR_W-1:0] STD_WRITE0_LOW = 11'd240;
   localparam logic [DUR_W-1:0] STD_WRITE0_REL = 11'd4;
   localparam logic [DUR_W-1:0] STD_WRITE0_REC = 11'd36;
   localparam logic [DUR_W-1:0] STD_WRITE1_LOW = 11'd24;
   localparam logic [DUR_W-1:0] STD_WRITE1_REL = 11'd36;
   localparam logic [DUR_W-1:0] STD_WRITE1_REC = 11'd220;
   localparam logic [DUR_W-1:0] STD_READ_LOW   = 11'd24;
   localparam logic [DUR_W-1:0] STD_READ_REL   = 11'd36;
   localparam logic [DUR_W-1:0] STD_READ_REC   = 11'd220;

   // Overdrive durations (qus)
   localparam logic [DUR_W-1:0] OD_RESET_LOW   = 11'd280;
   localparam logic [DUR_W-1:0] OD_RESET_REL   = 11'd34;
   localparam logic [DUR_W-1:0] OD_RESET_REC   = 11'd160;
   localparam logic [DUR_W-1:0] OD_WRITE0_LOW  = 11'd30;
   localparam logic [DUR_W-1:0] OD_WRITE0_REL  = 11'd4;
   localparam logic [DUR_W-1:0] OD_WRITE0_REC  = 11'd6;
   localparam logic [DUR_W-1:0] OD_WRITE1_LOW  = 11'd4;
   localparam logic [DUR_W-1:0] OD_WRITE1_REL  = 11'd4;
   localparam logic [DUR_W-1:0] OD_WRITE1_REC  = 11'd32;
   localparam logic [DUR_W-1:0] OD_READ_LOW    = 11'd4;
   localparam logic [DUR_W-1:0] OD_READ_REL    = 11'd4;
   localparam logic [DUR_W-1:0] OD_READ_REC    = 11'd32;

   // Duration in qus of the given phase of a slot; IDLE maps to the LOW duration
   function automatic logic [DUR_W-1:0] phase_qus(input logic [1:0] slot,
                                                  input logic       od,
                                                  input logic [1:0] state);
      logic [DUR_W-1:0] d_low;
      logic [DUR_W-1:0] d_rel;
      logic [DUR_W-1:0] d_rec;
      d_low = STD_READ_LOW;
      d_rel = STD_READ_REL;
      d_rec = STD_READ_REC;
      case ({od, slot})
         3'b000: begin d_low = STD_RESET_LOW;  d_rel = STD_RESET_REL;  d_rec = STD_RESET_REC;  end
         3'b001: begin d_low = STD_WRITE0_LOW; d_rel = STD_WRITE0_REL; d_rec = STD_WRITE0_REC; end
         3'b010: begin d_low = STD_WRITE1_LOW; d_rel = STD_WRITE1_REL; d_rec = STD_WRITE1_REC; end
         3'b011: begin d_low = STD_READ_LOW;   d_rel = STD_READ_REL;   d_rec = STD_READ_REC;   end
         3'b100: begin d_low = OD_RESET_LOW;   d_rel = OD_RESET_REL;   d_rec = OD_RESET_REC;   end
         3'b101: begin d_low = OD_WRITE0_LOW;  d_rel = OD_WRITE0_REL;  d_rec = OD_WRITE0_REC;  end
         3'b110: begin d_low = OD_WRITE1_LOW;  d_rel = OD_WRITE1_REL;  d_rec = OD_WRITE1_REC;  end
         3'b111: begin d_low = OD_READ_LOW;    d_rel = OD_READ_REL;    d_rec = OD_READ_REC;    end
      endcase
      case (state)
         ST_REL:  phase_qus = d_rel;
         ST_REC:  phase_qus = d_rec;
         default: phase_qus = d_low;
      endcase
   endfunction

endpackage

// File: rtl/one_wire_tick_gen.sv
// Quarter-microsecond prescaler: one-cycle tick every DIV clocks, restartable.
module one_wire_tick_gen #(
   parameter int unsigned DIV = 12
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_restart,
   output logic o_tick_c
);

   localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] r_cnt;

   // Count 0..DIV-1; restart forces the count back to 0
   always_ff @(posedge i_clk) begin
      if (i_rst || i_restart) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + PW'(1);
      end
   end

   assign o_tick_c = (r_cnt == LAST);

endmodule

// File: rtl/one_wire_slot_timer.sv
// 1-Wire slot sequencer: LOW/REL/REC phases timed in qus, with DQ sampling.
import one_wire_pkg::*;

module one_wire_slot_timer #(
   parameter int unsigned CLK_FREQ_HZ  = 48_000_000,
   parameter int unsigned OVERDRIVE_EN = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] slot_type,
   input  logic       overdrive,
   input  logic       abort,
   input  logic       dq_in,
   output logic       dq_drive_low,
   output logic       busy,
   output logic       done,
   output logic       rx_bit,
   output logic       presence
);

   localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;

   if ((CLK_FREQ_HZ % TICK_HZ) != 0 || CLK_FREQ_HZ < TICK_HZ) begin : g_bad_clk
      $error("one_wire_slot_timer: CLK_FREQ_HZ must be a non-zero multiple of 4 MHz");
   end

   logic [1:0]       r_state;
   logic [1:0]       r_slot;
   logic             r_od;
   logic [DUR_W-1:0] r_qus_cnt;
   logic             r_dq_meta;
   logic             r_dq_s;
   logic             r_dq_drive_low;
   logic             r_busy;
   logic             r_done;
   logic             r_rx_bit;
   logic             r_presence;

   logic [1:0]       w_next_state;
   logic             w_restart;
   logic             w_sample;
   logic             w_done;
   logic             w_phase_end;
   logic             w_tick;
   logic [DUR_W-1:0] w_dur;

   one_wire_tick_gen #(.DIV(DIV)) u_tick (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_restart (w_restart),
      .o_tick_c  (w_tick)
   );

   // Two-flop synchroniser for the raw pad level
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dq_meta <= 1'b1;
         r_dq_s    <= 1'b1;
      end else begin
         r_dq_meta <= dq_in;
         r_dq_s    <= r_dq_meta;
      end
   end

   // Next-state logic; abort overrides any phase transition or sample
   always_comb begin
      w_next_state = r_state;
      w_restart    = 1'b0;
      w_sample     = 1'b0;
      w_done       = 1'b0;
      w_dur        = phase_qus(r_slot, r_od, r_state);
      w_phase_end  = w_tick && (r_qus_cnt == (w_dur - 11'd1));
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next_state = ST_LOW;
               w_restart    = 1'b1;
            end
         end
         ST_LOW: begin
            if (abort) begin
               w_next_state = ST_IDLE;
            end else if (w_phase_end) begin
               w_next_state = ST_REL;
               w_restart    = 1'b1;
            end
         end
         ST_REL: begin
            if (abort) begin
               w_next_state = ST_IDLE;
            end else if (w_phase_end) begin
               w_next_state = ST_REC;
               w_restart    = 1'b1;
               w_sample     = 1'b1;
            end
         end
         default: begin
            if (abort) begin
               w_next_state = ST_IDLE;
            end else if (w_phase_end) begin
               w_next_state = ST_IDLE;
               w_restart    = 1'b1;
               w_done       = 1'b1;
            end
         end
      endcase
   end

   // State, phase counter, slot latch and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_slot         <= SLOT_RESET;
         r_od           <= 1'b0;
         r_qus_cnt      <= '0;
         r_dq_drive_low <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_restart) begin
            r_qus_cnt <= '0;
         end else if (w_tick && (r_state != ST_IDLE)) begin
            r_qus_cnt <= r_qus_cnt + 11'd1;
         end
         if ((r_state == ST_IDLE) && start) begin
            r_slot <= slot_type;
            r_od   <= overdrive & (OVERDRIVE_EN != 0);
         end
         r_dq_drive_low <= (w_next_state == ST_LOW);
         r_busy         <= (w_next_state != ST_IDLE);
         r_done         <= w_done;
      end
   end

   // Sampled bus results, held until the next sampling slot
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_bit   <= 1'b1;
         r_presence <= 1'b0;
      end else if (w_sample) begin
         if (r_slot == SLOT_READ) begin
            r_rx_bit <= r_dq_s;
         end
         if (r_slot == SLOT_RESET) begin
            r_presence <= ~r_dq_s;
         end
      end
   end

   assign dq_drive_low = r_dq_drive_low;
   assign busy         = r_busy;
   assign done         = r_done;
   assign rx_bit       = r_rx_bit;
   assign presence     = r_presence;

endmodule

// File: tb/tb_one_wire_slot_timer.sv
// Scoreboard bench for one_wire_slot_timer at 48 MHz (12 clocks per qus).
module tb_one_wire_slot_timer;

   localparam int DIV = 12;
   localparam logic [1:0] S_RESET = 2'b00;
   localparam logic [1:0] S_W0    = 2'b01;
   localparam logic [1:0] S_W1    = 2'b10;
   localparam logic [1:0] S_READ  = 2'b11;
   localparam int K_DONE  = 0;
   localparam int K_ABORT = 1;
   localparam int K_RST   = 2;

   typedef struct {
      int   kind;
      int   end_edge;
      logic exp_rx;
      logic exp_pres;
      int   low_cyc;
      int   busy_cyc;
   } rec_t;

   // [overdrive][slot][LOW,REL,REC] in quarter microseconds
   int dur_tab [0:1][0:3][0:2] = '{
      '{ '{1920, 280, 1640}, '{240, 4, 36}, '{24, 36, 220}, '{24, 36, 220} },
      '{ '{ 280,  34,  160}, '{ 30, 4,  6}, '{ 4,  4,  32}, '{ 4,  4,  32} }
   };

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       start_se = 1'b0;
   logic [1:0] slot_type = 2'b00;
   logic       overdrive = 1'b0;
   logic       abort = 1'b0;
   logic       dq_in = 1'b1;
   logic       dq_drive_low, busy, done, rx_bit, presence;
   logic       se_dq_drive_low, se_busy, se_done, se_rx_bit, se_presence;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;
   int   prev_end = 0;
   logic model_rx = 1'b1;
   logic model_pres = 1'b0;
   int   win_lo = -1000;
   int   win_hi = -1000;
   logic win_v = 1'b1;
   rec_t q[$];

   one_wire_slot_timer #(.CLK_FREQ_HZ(48_000_000), .OVERDRIVE_EN(1)) dut (
      .clk(clk), .rst(rst), .start(start), .slot_type(slot_type), .overdrive(overdrive),
      .abort(abort), .dq_in(dq_in), .dq_drive_low(dq_drive_low), .busy(busy),
      .done(done), .rx_bit(rx_bit), .presence(presence)
   );

   one_wire_slot_timer #(.CLK_FREQ_HZ(48_000_000), .OVERDRIVE_EN(0)) dut_se (
      .clk(clk), .rst(rst), .start(start_se), .slot_type(slot_type), .overdrive(overdrive),
      .abort(abort), .dq_in(dq_in), .dq_drive_low(se_dq_drive_low), .busy(se_busy),
      .done(se_done), .rx_bit(se_rx_bit), .presence(se_presence)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Device model: fixed level around the sample point, random elsewhere
   always @(posedge clk) begin
      #1;
      if (cyc >= win_lo && cyc <= win_hi) dq_in = win_v;
      else dq_in = 1'($urandom_range(0, 1));
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops one expectation per slot end (done pulse or busy drop)
   int   low_cnt = 0;
   int   busy_cnt = 0;
   logic prev_busy = 1'b0;
   rec_t mon_r;
   always @(negedge clk) begin
      if (busy === 1'b1) busy_cnt++;
      if (dq_drive_low === 1'b1) low_cnt++;
      if (done === 1'b1 || (prev_busy && busy === 1'b0)) begin
         if (q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_slot_end: done=%0d busy=%0d with nothing pending at cycle %0d",
                     done, busy, cyc);
         end else begin
            mon_r = q.pop_front();
            check("end_cycle", cyc, mon_r.end_edge);
            check("done_pulse", done, 32'(mon_r.kind == K_DONE));
            check("rx_bit", rx_bit, mon_r.exp_rx);
            check("presence", presence, mon_r.exp_pres);
            check("dq_released_at_end", dq_drive_low, 0);
            if (mon_r.kind == K_DONE) begin
               check("low_cycles", low_cnt, mon_r.low_cyc);
               check("busy_cycles", busy_cnt, mon_r.busy_cyc);
            end
         end
         low_cnt  = 0;
         busy_cnt = 0;
      end
      prev_busy = (busy === 1'b1);
   end

   // Issue one slot and push its expected outcome
   task automatic run_slot(input logic [1:0] st, input logic od, input logic v,
                           input int abort_off, input int poke_off, input int rst_off,
                           input int gap, input logic abort_with_start);
      int   k, l_cyc, t_cyc, s_off;
      rec_t r;
      while (cyc < prev_end + gap) step();
      k     = cyc + 1;
      l_cyc = dur_tab[od][st][0] * DIV;
      s_off = (dur_tab[od][st][0] + dur_tab[od][st][1]) * DIV;
      t_cyc = s_off + dur_tab[od][st][2] * DIV;
      win_lo = k + s_off - 40;
      win_hi = k + s_off + 5;
      win_v  = v;
      r.low_cyc  = l_cyc;
      r.busy_cyc = t_cyc;
      if (rst_off > 0) begin
         r.kind = K_RST;
         r.end_edge = k + rst_off;
         model_rx = 1'b1;
         model_pres = 1'b0;
      end else if (abort_off > 0) begin
         r.kind = K_ABORT;
         r.end_edge = k + abort_off;
         if (abort_off > s_off) begin
            if (st == S_READ) model_rx = v;
            if (st == S_RESET) model_pres = ~v;
         end
      end else begin
         r.kind = K_DONE;
         r.end_edge = k + t_cyc;
         if (st == S_READ) model_rx = v;
         if (st == S_RESET) model_pres = ~v;
      end
      r.exp_rx   = model_rx;
      r.exp_pres = model_pres;
      q.push_back(r);
      start = 1'b1;
      slot_type = st;
      overdrive = od;
      abort = abort_with_start;
      step();
      start = 1'b0;
      abort = 1'b0;
      slot_type = 2'($urandom_range(0, 3));
      overdrive = 1'($urandom_range(0, 1));
      if (poke_off > 0) begin
         while (cyc < k + poke_off - 1) step();
         start = 1'b1;
         step();
         start = 1'b0;
      end
      if (r.kind == K_ABORT) begin
         while (cyc < k + abort_off - 1) step();
         abort = 1'b1;
         step();
         abort = 1'b0;
         prev_end = k + abort_off;
      end else if (r.kind == K_RST) begin
         while (cyc < k + rst_off - 1) step();
         rst = 1'b1;
         repeat (3) step();
         rst = 1'b0;
         prev_end = k + rst_off + 2;
      end else begin
         prev_end = k + t_cyc;
      end
   endtask

   initial begin
      #1_200_000;
      $display("FAIL watchdog: simulation exceeded its cycle budget at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int k, lowc, de, t_std;
      logic [1:0] st;
      logic od;
      int ab, pk, t_cyc, endo;

      // Reset state
      repeat (3) step();
      check("rst_dq_drive_low", dq_drive_low, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rx_bit", rx_bit, 1);
      check("rst_presence", presence, 0);
      rst = 1'b0;
      step();

      // abort while idle has no effect
      abort = 1'b1;
      repeat (2) step();
      abort = 1'b0;
      check("idle_abort_busy", busy, 0);
      check("idle_abort_dq", dq_drive_low, 0);
      prev_end = cyc;

      // Directed slots
      run_slot(S_W0,    1'b0, 1'b0, 0, 0, 0, 2, 1'b1);
      run_slot(S_READ,  1'b0, 1'b0, 0, 0, 0, 1, 1'b0);
      run_slot(S_READ,  1'b0, 1'b1, 0, 300, 0, 0, 1'b0);
      run_slot(S_RESET, 1'b1, 1'b0, 0, 0, 0, 3, 1'b0);
      run_slot(S_RESET, 1'b1, 1'b1, 0, 0, 0, 0, 1'b0);
      run_slot(S_READ,  1'b0, 1'b0, 0, 0, 0, 1, 1'b0);
      run_slot(S_RESET, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
      run_slot(S_READ,  1'b0, 1'b0, 0, 0, 400, 1, 1'b0);
      run_slot(S_RESET, 1'b0, 1'b0, 100, 40, 0, 1, 1'b0);
      run_slot(S_W1,    1'b0, 1'b1, 0, 50, 0, 0, 1'b0);

      // Randomised slots
      for (int i = 0; i < 8; i++) begin
         st = 2'($urandom_range(0, 3));
         od = ($urandom_range(0, 3) != 0);
         t_cyc = (dur_tab[od][st][0] + dur_tab[od][st][1] + dur_tab[od][st][2]) * DIV;
         ab = 0;
         pk = 0;
         if (st == S_RESET && !od) ab = $urandom_range(1, 3000);
         else if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, t_cyc - 1);
         endo = (ab > 0) ? ab : t_cyc;
         if (endo > 1 && $urandom_range(0, 1) == 1) pk = $urandom_range(1, endo - 1);
         run_slot(st, od, 1'($urandom_range(0, 1)), ab, pk, 0,
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      // Overdrive request ignored when overdrive support is disabled
      while (cyc < prev_end + 2) step();
      t_std = (dur_tab[0][S_W1][0] + dur_tab[0][S_W1][1] + dur_tab[0][S_W1][2]) * DIV;
      k = cyc + 1;
      start_se = 1'b1;
      slot_type = S_W1;
      overdrive = 1'b1;
      step();
      start_se = 1'b0;
      lowc = 0;
      de = -1;
      for (int n = 0; n < 5000 && de < 0; n++) begin
         if (se_dq_drive_low === 1'b1) lowc++;
         if (se_done === 1'b1) de = cyc;
         if (de < 0) step();
      end
      check("se_low_cycles", lowc, dur_tab[0][S_W1][0] * DIV);
      check("se_done_cycle", de, k + t_std);
      check("se_busy_at_done", se_busy, 0);
      check("se_rx_bit", se_rx_bit, 1);
      check("se_presence", se_presence, 0);
      prev_end = cyc;

      while (cyc < prev_end + 3) step();
      check("scoreboard_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
